// File: rtl/pe_array_sequencer.sv
// Control sequencer for an N x N output-stationary systolic array: preset, skewed operand pops, init pulses, drain, done.
// Optional build macro PE_SEQ_STALL_EN adds a 'stall' input that freezes the RUN pattern.
module pe_array_sequencer #(
  parameter int N  = 4,
  parameter int KW = 8
) (
  input  logic            clk,
  input  logic            rst,
`ifdef PE_SEQ_STALL_EN
  input  logic            stall,
`endif
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  output logic            busy,
  output logic            done,
  output logic            pe_preset,
  output logic [2*N-2:0]  pe_init,
  output logic [N-1:0]    row_en,
  output logic [N-1:0]    col_en,
  output logic            result_valid
);

  localparam int TW = KW + 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [KW-1:0]   r_kq;
  logic [TW-1:0]   r_t;
  logic [TW-1:0]   w_t_next;
  logic            r_result_valid;
  logic            w_result_valid_next;
  logic            w_stall;
  logic [TW-1:0]   w_kq_ext;
  logic [TW-1:0]   w_t_last;
  logic            w_run_active;

`ifdef PE_SEQ_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  assign w_kq_ext     = {4'b0000, r_kq};
  assign w_t_last     = w_kq_ext + TW'(2 * N - 3);
  assign w_run_active = (r_state == S_RUN) && !w_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_kq           <= '0;
      r_t            <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_t            <= w_t_next;
      r_result_valid <= w_result_valid_next;
      if (r_state == S_IDLE && start) begin
        r_kq <= k_len;
      end
    end
  end

  always_comb begin
    w_state_next        = r_state;
    w_t_next            = r_t;
    w_result_valid_next = r_result_valid;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next        = S_CLEAR;
          w_result_valid_next = 1'b0;
        end
      end
      S_CLEAR: begin
        w_t_next     = '0;
        w_state_next = (r_kq == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        // A stalled cycle neither advances t nor emits any strobe.
        if (!w_stall) begin
          if (r_t == w_t_last) begin
            w_state_next = S_DRAIN;
          end else begin
            w_t_next = r_t + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        w_state_next        = S_DONE;
        w_result_valid_next = 1'b1;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign pe_preset    = (r_state == S_CLEAR);
  assign result_valid = r_result_valid;

  // Lane gi is skewed by gi cycles and pops for kq cycles.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      if (gi == 0) begin : g_first
        assign row_en[gi] = w_run_active && (r_t < w_kq_ext);
      end else begin : g_rest
        assign row_en[gi] = w_run_active && (r_t >= TW'(gi)) &&
                            (r_t < w_kq_ext + TW'(gi));
      end
      assign col_en[gi] = row_en[gi];
    end

    for (genvar gi = 0; gi < 2 * N - 1; gi++) begin : g_diag
      assign pe_init[gi] = w_run_active && (r_t == TW'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Directed self-checking bench for pe_array_sequencer (N=4, KW=8).
module tb_pe_array_sequencer;
  localparam int N  = 4;
  localparam int KW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            stall;
  logic [KW-1:0]   k_len;
  logic            busy;
  logic            done;
  logic            pe_preset;
  logic [2*N-2:0]  pe_init;
  logic [N-1:0]    row_en;
  logic [N-1:0]    col_en;
  logic            result_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pe_array_sequencer #(.N(N), .KW(KW)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef PE_SEQ_STALL_EN
    .stall        (stall),
`endif
    .start        (start),
    .k_len        (k_len),
    .busy         (busy),
    .done         (done),
    .pe_preset    (pe_preset),
    .pe_init      (pe_init),
    .row_en       (row_en),
    .col_en       (col_en),
    .result_valid (result_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] exp_en(input int t, input int kq);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (t >= i && t < i + kq) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [2*N-2:0] exp_init(input int t);
    logic [2*N-2:0] r;
    r = '0;
    for (int d = 0; d <= 2 * N - 2; d++) begin
      if (t == d) r[d] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [31:0] all_out();
    return {13'd0, busy, done, pe_preset, pe_init, row_en, col_en, result_valid};
  endfunction

  // One pass from start; optional 2-cycle stall beginning at cycle stall_c,
  // optional stray start pulse at cycle mid_c. Cycle 0 is the start cycle.
  task automatic run_pass(input int kq, input int stall_c, input int mid_c, input string tag);
    int ext, lat, t;
    logic [N-1:0]     er;
    logic [2*N-2:0]   ei;
    bit               stalled;
    ext = (stall_c > 0) ? 2 : 0;
    lat = (kq == 0) ? 2 : kq + 2 * N + 1 + ext;
    k_len = kq[KW-1:0];
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      stalled = (stall_c > 0 && c >= stall_c && c < stall_c + 2);
      stall = stalled;
      start = (c == mid_c);
      #1;
      er = '0;
      ei = '0;
      if (kq > 0 && c >= 2 && c <= kq + 2 * N - 1 + ext && !stalled) begin
        t = (stall_c > 0 && c >= stall_c + 2) ? c - 4 : c - 2;
        er = exp_en(t, kq);
        ei = exp_init(t);
      end
      chk({tag, "_busy"},   32'(busy),         32'd1);
      chk({tag, "_done"},   32'(done),         32'(c == lat));
      chk({tag, "_preset"}, 32'(pe_preset),    32'(c == 1));
      chk({tag, "_row_en"}, 32'(row_en),       32'(er));
      chk({tag, "_col_en"}, 32'(col_en),       32'(er));
      chk({tag, "_init"},   32'(pe_init),      32'(ei));
      chk({tag, "_rvalid"}, 32'(result_valid), 32'(c == lat && kq > 0));
      step();
    end
    stall = 1'b0;
    start = 1'b0;
    chk({tag, "_idle_busy"},   32'(busy),         32'd0);
    chk({tag, "_idle_done"},   32'(done),         32'd0);
    chk({tag, "_idle_rvalid"}, 32'(result_valid), 32'(kq > 0));
    $display("pass %s k_len=%0d latency=%0d checks=%0d errors=%0d", tag, kq, lat, checks, errors);
  endtask

  int n;

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    stall = 1'b0;
    k_len = 8'd3;

    // Reset held 3 cycles with start asserted, then 10 quiet idle cycles.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_outputs", all_out(), 32'd0);
    end
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_outputs", all_out(), 32'd0);
    end
    $display("reset/idle phase checks=%0d errors=%0d", checks, errors);

    run_pass(3, 0, 0, "k3");
    run_pass(0, 0, 0, "k0");
    run_pass(3, 0, 5, "k3_midstart");
    for (int i = 0; i < 4; i++) begin
      step();
      chk("after_midstart_done", 32'(done), 32'd0);
    end

    // start held high: back-to-back passes with one IDLE cycle between.
    k_len = 8'd3;
    start = 1'b1;
    step();
    for (int c = 1; c <= 12; c++) begin
      chk("held_done", 32'(done), 32'(c == 12));
      step();
    end
    chk("held_gap_busy", 32'(busy), 32'd0);
    chk("held_gap_rvalid", 32'(result_valid), 32'd1);
    step();
    chk("held_second_preset", 32'(pe_preset), 32'd1);
    start = 1'b0;
    n = 0;
    while (!done && n < 30) begin
      step();
      n++;
    end
    chk("held_second_done_cycle", 32'(14 + n), 32'd25);
    step();
    chk("held_second_rvalid", 32'(result_valid), 32'd1);
    $display("held-start phase checks=%0d errors=%0d", checks, errors);

    // Reset at t=4 of a k_len=5 pass.
    k_len = 8'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("abort_row_en_t4", 32'(row_en), 32'h0000000F);
    chk("abort_init_t4", 32'(pe_init), 32'h00000010);
    rst = 1'b1;
    step();
    chk("abort_outputs", all_out(), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("abort_no_done", all_out(), 32'd0);
    end
    $display("abort phase checks=%0d errors=%0d", checks, errors);
    run_pass(5, 0, 0, "k5_fresh");

    run_pass(255, 0, 0, "kmax");

`ifdef PE_SEQ_STALL_EN
    run_pass(3, 4, 0, "k3_stall");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
